// File: rtl/seg7_helo_decoder.sv
// Loop-back checker for the HELO seven-segment character set: decodes each pattern
// to its 3-bit code, spots complete "HELLO" words and keeps saturating tallies.
module seg7_helo_decoder #(
  parameter int CNT_W        = 8,
  parameter bit BLANK_BREAKS = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [0:6]       seg_in,
  input  logic             seg_valid,
  output logic [2:0]       code_out,
  output logic             code_valid,
  output logic             seg_err,
  output logic             hello,
  output logic [CNT_W-1:0] hello_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {IDLE, GOT_H, GOT_E, GOT_L1, GOT_L2} state_t;

  // Table order fixes the match indices: 0=H 1=E 2=L 3=O 4=blank
  localparam logic [6:0] PAT  [5] = '{7'h48, 7'h30, 7'h71, 7'h01, 7'h7F};
  localparam logic [2:0] CODE [5] = '{3'h0, 3'h1, 3'h2, 3'h3, 3'h7};

  logic [6:0]       seg_word;
  logic [4:0]       match;
  logic [2:0]       code_dec;
  logic             illegal;
  state_t           state_reg, state_next;
  logic             hello_next;
  logic [2:0]       code_reg;
  logic             valid_reg, err_reg, hello_reg;
  logic [CNT_W-1:0] hello_cnt_reg, err_cnt_reg;

  assign seg_word = seg_in;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_match
      assign match[gi] = (seg_word == PAT[gi]);
    end
  endgenerate

  always_comb begin
    code_dec = 3'h4;
    illegal  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (match[i]) begin
        code_dec = CODE[i];
        illegal  = 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    hello_next = 1'b0;
    if (seg_valid) begin
      // An H always restarts the word, whatever came before it
      if (match[0]) begin
        state_next = GOT_H;
      end else if (illegal) begin
        state_next = IDLE;
      end else if (match[4]) begin
        state_next = BLANK_BREAKS ? IDLE : state_reg;
      end else begin
        state_next = IDLE;
        case (state_reg)
          GOT_H:  if (match[1]) state_next = GOT_E;
          GOT_E:  if (match[2]) state_next = GOT_L1;
          GOT_L1: if (match[2]) state_next = GOT_L2;
          GOT_L2: if (match[3]) hello_next = 1'b1;
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      code_reg      <= 3'h7;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
      hello_reg     <= 1'b0;
      hello_cnt_reg <= '0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      valid_reg <= seg_valid;
      hello_reg <= hello_next;
      if (seg_valid) begin
        code_reg <= code_dec;
        err_reg  <= illegal;
      end
      if (hello_next && (hello_cnt_reg != '1))
        hello_cnt_reg <= hello_cnt_reg + 1'b1;
      if (seg_valid && illegal && (err_cnt_reg != '1))
        err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign code_out   = code_reg;
  assign code_valid = valid_reg;
  assign seg_err    = err_reg;
  assign hello      = hello_reg;
  assign hello_cnt  = hello_cnt_reg;
  assign err_cnt    = err_cnt_reg;

endmodule
